// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types, digit limits and the BCD step helper used by
//                the stopwatch timekeeping core.
//  Contents    : state_t       - control state (IDLE, RUNNING, PAUSED)
//                *_MAX         - terminal value of each BCD digit position
//                bcd_step()    - next value of one BCD digit given an increment
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] UNITS_MAX    = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

    // Value a digit takes after one clock: wraps to 0 past its maximum.
    function automatic logic [3:0] bcd_step(input logic [3:0] value,
                                            input logic       inc,
                                            input logic [3:0] max_value);
        logic [3:0] r;
        r = value;
        if (inc) begin
            r = (value == max_value) ? 4'd0 : 4'(value + 4'd1);
        end
        return r;
    endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_counter
//  Description : One decimal digit of a cascaded BCD counter. Counts 0..MAX
//                and wraps to 0, signalling carry on the wrapping increment.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous active-high reset (value -> 0)
//                clr    - synchronous clear, takes priority over inc
//                inc    - advance by one this cycle
//                value  - current digit (registered)
//                carry  - combinational, inc && value == MAX
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] r_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= 4'd0;
        end else if (clr) begin
            r_value <= 4'd0;
        end else begin
            r_value <= bcd_step(r_value, inc, MAX);
        end
    end

    assign value = r_value;
    assign carry = inc && (r_value == MAX);

endmodule : bcd_digit_counter
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_counter
//  Description : Stopwatch timekeeping core. Divides clk to a 1 s tick and
//                counts MM:SS in BCD (00:00..59:59) with start/pause, clear
//                and lap-hold control. All outputs are registered.
//  Ports       : clk, reset (async, active-high)
//                start_stop, clear, lap - single-cycle control pulses
//                minutes_tens/units, seconds_tens/units - displayed BCD digits
//                running    - high in RUNNING
//                lap_active - high while the display is frozen
//                rollover   - one-cycle pulse after the 59:59 -> 00:00 wrap
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLKS_PER_TICK = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] minutes_tens,
    output logic [3:0] minutes_units,
    output logic [3:0] seconds_tens,
    output logic [3:0] seconds_units,
    output logic       running,
    output logic       lap_active,
    output logic       rollover
);

    localparam int                   c_PRESC_W    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(CLKS_PER_TICK - 1);

    state_t               r_state;
    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_running;
    logic                 r_lap_active;
    logic                 r_rollover;
    logic [15:0]          r_disp;

    logic        w_tick;
    logic [3:0]  w_su, w_st, w_mu, w_mt;
    logic        w_su_carry, w_st_carry, w_mu_carry, w_mt_carry;
    logic [15:0] w_live_next;
    logic        w_lap_capture;
    logic        w_lap_release;

    // ------------------------------------------------------------------
    // Prescaler: frozen outside RUNNING so a resume continues mid-second.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (clear) begin
            r_presc <= '0;
        end else if (r_state == RUNNING) begin
            r_presc <= (r_presc == c_PRESC_LAST) ? '0 : c_PRESC_W'(r_presc + 1'b1);
        end
    end

    assign w_tick = (r_state == RUNNING) && !clear && (r_presc == c_PRESC_LAST);

    // ------------------------------------------------------------------
    // Live count: four cascaded digits.
    // ------------------------------------------------------------------
    bcd_digit_counter #(.MAX(UNITS_MAX)) u_sec_units (
        .clk(clk), .reset(reset), .clr(clear), .inc(w_tick),
        .value(w_su), .carry(w_su_carry)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .clr(clear), .inc(w_su_carry),
        .value(w_st), .carry(w_st_carry)
    );

    bcd_digit_counter #(.MAX(UNITS_MAX)) u_min_units (
        .clk(clk), .reset(reset), .clr(clear), .inc(w_st_carry),
        .value(w_mu), .carry(w_mu_carry)
    );

    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .clr(clear), .inc(w_mu_carry),
        .value(w_mt), .carry(w_mt_carry)
    );

    // Value the live count will hold after this edge; lets the display
    // registers track the count with no added latency and lets a lap
    // capture include an increment happening on the same edge.
    assign w_live_next = clear ? 16'h0000 :
                         {bcd_step(w_mt, w_mu_carry, MIN_TENS_MAX),
                          bcd_step(w_mu, w_st_carry, UNITS_MAX),
                          bcd_step(w_st, w_su_carry, SEC_TENS_MAX),
                          bcd_step(w_su, w_tick,     UNITS_MAX)};

    assign w_lap_capture = lap && !clear && !r_lap_active && (r_state == RUNNING);
    assign w_lap_release = lap && !clear &&  r_lap_active && (r_state != IDLE);

    // ------------------------------------------------------------------
    // Control FSM with registered status, lap hold and display registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_rollover   <= 1'b0;
            r_disp       <= 16'h0000;
        end else begin
            r_rollover <= w_mt_carry;

            if (clear) begin
                r_state   <= IDLE;
                r_running <= 1'b0;
            end else if (start_stop) begin
                case (r_state)
                    IDLE, PAUSED: begin
                        r_state   <= RUNNING;
                        r_running <= 1'b1;
                    end
                    RUNNING: begin
                        r_state   <= PAUSED;
                        r_running <= 1'b0;
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end

            if (clear || w_lap_release) begin
                r_lap_active <= 1'b0;
            end else if (w_lap_capture) begin
                r_lap_active <= 1'b1;
            end

            // Hold the frozen value only while the lap stays active.
            if (!r_lap_active || w_lap_release || clear) begin
                r_disp <= w_live_next;
            end
        end
    end

    assign minutes_tens  = r_disp[15:12];
    assign minutes_units = r_disp[11:8];
    assign seconds_tens  = r_disp[7:4];
    assign seconds_units = r_disp[3:0];
    assign running       = r_running;
    assign lap_active    = r_lap_active;
    assign rollover      = r_rollover;

endmodule : stopwatch_counter
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_counter
//  Description : Directed self-checking bench for stopwatch_counter with
//                CLKS_PER_TICK = 4. Inputs change and outputs are sampled
//                1 ns after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

    logic       clk;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] minutes_tens;
    logic [3:0] minutes_units;
    logic [3:0] seconds_tens;
    logic [3:0] seconds_units;
    logic       running;
    logic       lap_active;
    logic       rollover;
    logic [15:0] disp;

    int errors = 0;
    int checks = 0;

    stopwatch_counter #(.CLKS_PER_TICK(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_stop    (start_stop),
        .clear         (clear),
        .lap           (lap),
        .minutes_tens  (minutes_tens),
        .minutes_units (minutes_units),
        .seconds_tens  (seconds_tens),
        .seconds_units (seconds_units),
        .running       (running),
        .lap_active    (lap_active),
        .rollover      (rollover)
    );

    assign disp = {minutes_tens, minutes_units, seconds_tens, seconds_units};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until the display shows target or the budget runs out.
    task automatic wait_disp(input logic [15:0] target, input int budget, output int n);
        n = 0;
        while (disp !== target && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({disp, running, lap_active, rollover} !== 19'h0) begin
            errors++;
            $display("FAIL reset_state: got disp=%h run=%b lap=%b roll=%b, expected all zero",
                     disp, running, lap_active, rollover);
        end
        reset = 1'b0;
        step();
        checks++;
        if (disp !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got disp=%h run=%b, expected 0000 0", disp, running);
        end
    endtask

    task automatic test_count();
        start_stop = 1'b1;
        step();                       // edge 0
        start_stop = 1'b0;
        checks++;
        if (running !== 1'b1 || disp !== 16'h0000) begin
            errors++;
            $display("FAIL start_running: got run=%b disp=%h, expected 1 0000", running, disp);
        end
        repeat (3) step();            // edge 3
        checks++;
        if (disp !== 16'h0000) begin
            errors++;
            $display("FAIL before_first_tick: got %h expected 0000", disp);
        end
        step();                       // edge 4
        checks++;
        if (disp !== 16'h0001) begin
            errors++;
            $display("FAIL first_tick: got %h expected 0001", disp);
        end
        repeat (4) step();            // edge 8
        checks++;
        if (disp !== 16'h0002 || rollover !== 1'b0) begin
            errors++;
            $display("FAIL second_tick: got disp=%h roll=%b expected 0002 0", disp, rollover);
        end
    endtask

    task automatic test_carry_rollover();
        int n;
        wait_disp(16'h0059, 400, n);
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL reach_0059: got %h expected 0059 within budget", disp);
        end
        repeat (3) step();
        checks++;
        if (disp !== 16'h0059) begin
            errors++;
            $display("FAIL hold_0059: got %h expected 0059", disp);
        end
        step();
        checks++;
        if (disp !== 16'h0100) begin
            errors++;
            $display("FAIL minute_carry: got %h expected 0100", disp);
        end
        wait_disp(16'h5959, 16000, n);
        checks++;
        if (n >= 16000) begin
            errors++;
            $display("FAIL reach_5959: got %h expected 5959 within budget", disp);
        end
        repeat (3) step();
        checks++;
        if (disp !== 16'h5959 || rollover !== 1'b0) begin
            errors++;
            $display("FAIL pre_wrap: got disp=%h roll=%b expected 5959 0", disp, rollover);
        end
        step();
        checks++;
        if (disp !== 16'h0000 || rollover !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL wrap: got disp=%h roll=%b run=%b expected 0000 1 1",
                     disp, rollover, running);
        end
        step();
        checks++;
        if (rollover !== 1'b0 || disp !== 16'h0000) begin
            errors++;
            $display("FAIL rollover_one_cycle: got roll=%b disp=%h expected 0 0000", rollover, disp);
        end
    endtask

    task automatic test_pause_resume();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (disp !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle: got disp=%h run=%b expected 0000 0", disp, running);
        end
        start_stop = 1'b1;
        step();                       // edge 0, prescaler 0
        start_stop = 1'b0;
        repeat (4) step();            // edge 4: 00:01, prescaler 0
        checks++;
        if (disp !== 16'h0001) begin
            errors++;
            $display("FAIL pause_setup: got %h expected 0001", disp);
        end
        step();                       // edge 5: prescaler 1
        start_stop = 1'b1;
        step();                       // edge 6: prescaler 2, paused
        start_stop = 1'b0;
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL paused: got run=%b expected 0", running);
        end
        repeat (20) step();
        checks++;
        if (disp !== 16'h0001) begin
            errors++;
            $display("FAIL pause_hold: got %h expected 0001", disp);
        end
        start_stop = 1'b1;
        step();                       // resume edge R
        start_stop = 1'b0;
        step();                       // R+1
        checks++;
        if (disp !== 16'h0001 || running !== 1'b1) begin
            errors++;
            $display("FAIL resume_r1: got disp=%h run=%b expected 0001 1", disp, running);
        end
        step();                       // R+2
        checks++;
        if (disp !== 16'h0002) begin
            errors++;
            $display("FAIL resume_r2: got %h expected 0002", disp);
        end
    endtask

    task automatic test_lap();
        clear = 1'b1;
        step();
        clear = 1'b0;
        start_stop = 1'b1;
        step();                       // edge 0
        start_stop = 1'b0;
        repeat (20) step();           // edge 20: 00:05
        lap = 1'b1;
        step();                       // edge 21
        lap = 1'b0;
        checks++;
        if (disp !== 16'h0005 || lap_active !== 1'b1) begin
            errors++;
            $display("FAIL lap_freeze: got disp=%h lap=%b expected 0005 1", disp, lap_active);
        end
        repeat (11) step();           // edge 32: live 00:08
        checks++;
        if (disp !== 16'h0005 || running !== 1'b1) begin
            errors++;
            $display("FAIL lap_held: got disp=%h run=%b expected 0005 1", disp, running);
        end
        repeat (4) step();            // edge 36: live 00:09
        lap = 1'b1;
        step();                       // edge 37
        lap = 1'b0;
        checks++;
        if (disp !== 16'h0009 || lap_active !== 1'b0) begin
            errors++;
            $display("FAIL lap_release: got disp=%h lap=%b expected 0009 0", disp, lap_active);
        end
        repeat (2) step();            // edge 39
        lap = 1'b1;
        step();                       // edge 40: increment to 00:10 on the lap edge
        lap = 1'b0;
        checks++;
        if (disp !== 16'h0010 || lap_active !== 1'b1) begin
            errors++;
            $display("FAIL lap_on_tick: got disp=%h lap=%b expected 0010 1", disp, lap_active);
        end
        repeat (4) step();            // edge 44: live 00:11
        lap = 1'b1;
        step();                       // edge 45
        lap = 1'b0;
        checks++;
        if (disp !== 16'h0011 || lap_active !== 1'b0) begin
            errors++;
            $display("FAIL lap_release2: got disp=%h lap=%b expected 0011 0", disp, lap_active);
        end
    endtask

    task automatic test_clear_priority();
        int n;
        clear = 1'b1;
        step();
        clear = 1'b0;
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        wait_disp(16'h0327, 1000, n);
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL reach_0327: got %h expected 0327 within budget", disp);
        end
        lap = 1'b1;
        step();
        lap = 1'b0;
        clear = 1'b1;
        start_stop = 1'b1;
        step();
        clear = 1'b0;
        start_stop = 1'b0;
        checks++;
        if (disp !== 16'h0000 || running !== 1'b0 || lap_active !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins: got disp=%h run=%b lap=%b expected 0000 0 0",
                     disp, running, lap_active);
        end
        repeat (8) step();
        lap = 1'b1;
        step();
        lap = 1'b0;
        checks++;
        if (lap_active !== 1'b0 || disp !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL lap_in_idle: got disp=%h run=%b lap=%b expected 0000 0 0",
                     disp, running, lap_active);
        end
        repeat (8) step();
        checks++;
        if (disp !== 16'h0000) begin
            errors++;
            $display("FAIL idle_stays: got %h expected 0000", disp);
        end
    endtask

    task automatic test_async_reset();
        int n;
        clear = 1'b1;
        step();
        clear = 1'b0;
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        wait_disp(16'h1234, 3200, n);
        checks++;
        if (n >= 3200) begin
            errors++;
            $display("FAIL reach_1234: got %h expected 1234 within budget", disp);
        end
        lap = 1'b1;
        step();
        lap = 1'b0;
        step();
        #2;                           // between edges
        reset = 1'b1;
        #1;
        checks++;
        if ({disp, running, lap_active, rollover} !== 19'h0) begin
            errors++;
            $display("FAIL async_reset: got disp=%h run=%b lap=%b roll=%b expected all zero",
                     disp, running, lap_active, rollover);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) step();
        checks++;
        if (disp !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got disp=%h run=%b expected 0000 0", disp, running);
        end
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        repeat (3) step();
        checks++;
        if (disp !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_prescaler: got %h expected 0000", disp);
        end
        step();
        checks++;
        if (disp !== 16'h0001) begin
            errors++;
            $display("FAIL post_reset_first_tick: got %h expected 0001", disp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        test_reset();
        test_count();
        test_carry_rollover();
        test_pause_resume();
        test_lap();
        test_clear_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_stopwatch_counter
`default_nettype wire
